// File: rtl/flex_down_timer.sv
// flex_down_timer: programmable down-counting timer with start/stop handshake.
// Optional periodic mode compiled in with FLEX_DOWN_TIMER_RELOAD_EN.
module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] load_val,
`ifdef FLEX_DOWN_TIMER_RELOAD_EN
    input  logic                    auto_reload,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    zero_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    state_e                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    done_q, done_d;
    logic                    reload_en;

`ifdef FLEX_DOWN_TIMER_RELOAD_EN
    assign reload_en = auto_reload;
`else
    assign reload_en = 1'b0;
`endif

    // State, count, reload value and done pulse registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state: clear beats stop, stop beats counting/start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (stop && (state_q == RUN)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        count_d  = load_val;
                        reload_d = load_val;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (count_enable) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else begin
                            // Terminal step: counts of 1 and 0 both end here.
                            done_d = 1'b1;
                            if (reload_en) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign count_out = count_q;
    assign zero_flag = (count_q == '0);

endmodule

// File: doc/flex_down_timer.md
# flex_down_timer

Programmable down-counting timer with a start/stop handshake. It is the counting-down counterpart of the flexible up-counter used across the MCU. A controller loads a terminal count, starts the timer, and receives a one-cycle `done` pulse when the count is exhausted. It sits beside the MCU sequencer to time wait intervals and measurement windows for the filter datapath.

## Interface
- `NUM_CNT_BITS`, default 4, width of the count, load value and reload register.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `n_rst`  input  1  reset; one clock, reset is asynchronous and active-low.
- `clear`  input  1  synchronous clear; highest priority after reset.
- `start`  input  1  level-sampled start request; honoured only in IDLE.
- `stop`  input  1  abort request; honoured only in RUN.
- `count_enable`  input  1  decrement qualifier in RUN.
- `load_val`  input  NUM_CNT_BITS  terminal count, captured on an accepted start.
- `auto_reload`  input  1  present only with `FLEX_DOWN_TIMER_RELOAD_EN` (see Configuration).
- `busy`  output  1  high while in RUN.
- `done`  output  1  registered one-cycle pulse on terminal count.
- `count_out`  output  NUM_CNT_BITS  current count register.
- `zero_flag`  output  1  `count_out == 0`, combinational from the register.

## Operation
- **States**
  - IDLE and RUN, 1-bit state register.
  - `busy` = (state == RUN).
- **Reset values**
  - State IDLE.
  - `count_out` = 0, so `zero_flag` = 1.
  - Reload register 0.
  - `busy` = 0, `done` = 0.
- **Priority** each cycle: `clear`, then `stop`, then counting/start.
- **`clear`**
  - state ← IDLE, count ← 0, `done` ← 0.
  - Reload register is unchanged.
- **IDLE**
  - On `start`=1: count ← `load_val`, reload register ← `load_val`, state ← RUN.
  - Otherwise the count holds its last value.
  - `stop` is ignored.
- **RUN**
  - `start` is ignored. `load_val` changes have no effect.
  - `stop`=1: state ← IDLE, count holds, no `done`.
  - `count_enable`=0: count holds.
  - `count_enable`=1 with count > 1: count ← count − 1.
  - `count_enable`=1 with count ≤ 1 is the terminal step: count ← 0, state ← IDLE, `done` ← 1.
  - A loaded value of 0 therefore terminates on the first enabled cycle.
- **`done`**
  - Next-state is 1 only on a terminal step; otherwise 0.
  - It never stays high for two consecutive cycles, except under auto-reload with a reload value ≤ 1.
- **Width rules**
  - Unsigned arithmetic, no wrap-around below 0.
  - `load_val` = 2^N−1 is legal.

## Timing
- `start` sampled high at edge k: `busy`=1 and `count_out`=L after edge k.
- With `count_enable` held high, the count reads L−1 … 0 after edges k+1 … k+L.
- The terminal edge is k+L (k+1 for L=0). After that edge, `done`=1 and `busy`=0 for exactly one cycle.
- A new `start` is accepted at edge k+L+1 at the earliest. `start` sampled while `done`=1 is accepted, because the state is IDLE.
- Each low cycle of `count_enable` in RUN extends latency by one cycle.
- An asynchronous `n_rst` mid-RUN forces the reset values immediately and suppresses any pending `done`.

## Configuration
- **`FLEX_DOWN_TIMER_RELOAD_EN` defined**
  - The `auto_reload` port exists.
  - On a terminal step with `auto_reload`=1: count ← reload register, state stays RUN, `busy` stays 1, `done` ← 1.
  - This gives a periodic `done` every L enabled cycles (every cycle for L ≤ 1).
  - `stop` or `clear` ends periodic mode.
- **Not defined**
  - The port is absent and every terminal step returns to IDLE.

## Test plan
- **Reset:** assert `n_rst`=0 mid-RUN with count=5 → immediately `count_out`=0, `busy`=0, `done`=0, `zero_flag`=1.
- **Basic count:** `load_val`=4, 1-cycle `start`, `count_enable`=1 → `count_out` 4,3,2,1,0 on successive edges; `done`=1 for one cycle with `busy`=0, 4 edges after start.
- **Enable gaps and zero load:**
  - `load_val`=3 with `count_enable` low every other cycle → `done` 6 edges after start.
  - `load_val`=0 → `done` one edge after start.
- **Priority:**
  - `stop` in RUN at count=2 → IDLE, count stays 2, no `done`.
  - `clear` and `stop` together → count 0.
  - `start` in RUN with `load_val`=9 → no effect.
- **Back-to-back:** `start` held high continuously with `load_val`=2 → `done` on every third cycle, with `busy` low only in the `done` cycles.
- **Reload (macro defined):** `auto_reload`=1, `load_val`=3 → `done` every 3 enabled cycles, `busy` constant 1; `stop` ends it.
